// File: rtl/key_event_decoder_pkg.sv
// key_evt_pkg: shared states, event bundle and default timing for key_event_decoder
package key_evt_pkg;
  localparam int DEF_CLK_HZ = 24_000_000;
  localparam int DEF_LONG_MS = 1000;
  localparam int DEF_DBL_MS = 300;
  localparam int DEF_REPEAT_MS = 200;
  localparam int MS_W = 16;
  typedef enum logic [4:0] {
    IDLE     = 5'b00001,
    PRESSED  = 5'b00010,
    HELD     = 5'b00100,
    WAIT_DBL = 5'b01000,
    PRESSED2 = 5'b10000
  } state_t;
  typedef struct packed {
    logic short_p;
    logic long_p;
    logic rep;
    logic dbl;
  } evt_t;
endpackage

// File: rtl/key_event_decoder_if.sv
// key_event_decoder_if: debounced key input and classified event outputs
interface key_event_decoder_if;
  logic KEY_FLAG;
  logic KEY_STATE;
  logic SHORT_PRESS;
  logic LONG_PRESS;
  logic REPEAT;
  logic DOUBLE_CLICK;
  logic KEY_HELD;
  modport master(
    output KEY_FLAG, KEY_STATE,
    input  SHORT_PRESS, LONG_PRESS, REPEAT, DOUBLE_CLICK, KEY_HELD
  );
  modport slave(
    input  KEY_FLAG, KEY_STATE,
    output SHORT_PRESS, LONG_PRESS, REPEAT, DOUBLE_CLICK, KEY_HELD
  );
endinterface

// File: rtl/key_event_decoder_ms_timer.sv
// ms_timer: 1 ms prescaler driving a saturating millisecond counter
module ms_timer
  import key_evt_pkg::*;
#(
  parameter int CLK_HZ = DEF_CLK_HZ
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            clr,
  output logic [MS_W-1:0] ms_cnt,
  output logic            ms_wrap
);
  localparam int P = CLK_HZ / 1000;
  localparam int PW = P > 1 ? $clog2(P) : 1;
  localparam logic [PW-1:0] P_TC = PW'(P - 1);
  logic [PW-1:0] pre;
  assign ms_wrap = pre == P_TC;
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      pre <= '0;
      ms_cnt <= '0;
    end else if (clr) begin
      pre <= '0;
      ms_cnt <= '0;
    end else begin
      pre <= ms_wrap ? '0 : pre + 1'b1;
      ms_cnt <= (ms_wrap && ms_cnt != '1) ? ms_cnt + 1'b1 : ms_cnt;
    end
endmodule

// File: rtl/key_event_decoder.sv
// key_event_decoder: classifies debounced key gestures into short/long/double/repeat pulses
module key_event_decoder
  import key_evt_pkg::*;
#(
  parameter int CLK_HZ = DEF_CLK_HZ,
  parameter int LONG_MS = DEF_LONG_MS,
  parameter int DBL_MS = DEF_DBL_MS,
  parameter int REPEAT_MS = DEF_REPEAT_MS
) (
  input logic CLK,
  input logic nRST,
  key_event_decoder_if.slave bus
);
  // expiry is taken on the wrap that brings ms_cnt up to the threshold
  localparam logic [MS_W-1:0] LONG_T = MS_W'(LONG_MS - 1);
  localparam logic [MS_W-1:0] DBL_T = MS_W'(DBL_MS - 1);
  localparam logic [MS_W-1:0] REP_T = MS_W'(REPEAT_MS - 1);
  state_t st, nxt;
  evt_t e, evt_q, out_q;
  logic held_q, rep_clr, clr, ms_wrap, press, rel, long_exp, dbl_exp, rep_exp;
  logic [MS_W-1:0] ms_cnt;
  assign press = bus.KEY_FLAG & ~bus.KEY_STATE;
  assign rel = bus.KEY_FLAG & bus.KEY_STATE;
  assign long_exp = ms_wrap && ms_cnt == LONG_T;
  assign dbl_exp = ms_wrap && ms_cnt == DBL_T;
  assign rep_exp = ms_wrap && ms_cnt == REP_T;
  assign clr = (nxt != st) || rep_clr;
  ms_timer #(.CLK_HZ(CLK_HZ)) u_timer (
    .CLK(CLK), .nRST(nRST), .clr(clr), .ms_cnt(ms_cnt), .ms_wrap(ms_wrap)
  );
  // key events are tested before timer expiries so a flag always wins
  always_comb begin
    nxt = st;
    e = '0;
    rep_clr = 1'b0;
    case (st)
      IDLE: nxt = press ? PRESSED : IDLE;
      PRESSED:
        if (rel) nxt = WAIT_DBL;
        else if (long_exp) begin
          nxt = HELD;
          e.long_p = 1'b1;
        end
      HELD:
        if (rel) nxt = IDLE;
        else if (rep_exp) begin
          e.rep = 1'b1;
          rep_clr = 1'b1;
        end
      WAIT_DBL:
        if (press) nxt = PRESSED2;
        else if (dbl_exp) begin
          nxt = IDLE;
          e.short_p = 1'b1;
        end
      PRESSED2:
        if (rel) begin
          nxt = IDLE;
          e.dbl = 1'b1;
        end else if (long_exp) begin
          nxt = HELD;
          e.long_p = 1'b1;
        end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      st <= IDLE;
      evt_q <= '0;
      out_q <= '0;
      held_q <= 1'b0;
    end else begin
      st <= nxt;
      evt_q <= e;
      out_q <= evt_q;
      held_q <= nxt inside {PRESSED, PRESSED2, HELD};
    end
  assign bus.SHORT_PRESS = out_q.short_p;
  assign bus.LONG_PRESS = out_q.long_p;
  assign bus.REPEAT = out_q.rep;
  assign bus.DOUBLE_CLICK = out_q.dbl;
  assign bus.KEY_HELD = held_q;
endmodule

// File: tb/tb_key_event_decoder.sv
// tb_key_event_decoder: directed gestures with a queued scoreboard of expected event pulses
module tb_key_event_decoder;
  localparam int CLK_HZ = 10_000, LONG_MS = 20, DBL_MS = 5, REPEAT_MS = 4;
  localparam int K_SHORT = 0, K_LONG = 1, K_REP = 2, K_DBL = 3;
  typedef struct {int kind; int at;} exp_t;
  logic CLK = 1'b0, nRST = 1'b0;
  int cyc = 0, total = 0, passed = 0;
  exp_t sb[$];
  key_event_decoder_if kif();
  key_event_decoder #(
    .CLK_HZ(CLK_HZ), .LONG_MS(LONG_MS), .DBL_MS(DBL_MS), .REPEAT_MS(REPEAT_MS)
  ) dut (.CLK(CLK), .nRST(nRST), .bus(kif));
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
  endtask
  function automatic void expect_evt(input int k, input int at);
    sb.push_back('{k, at});
  endfunction
  // flag is raised at the negedge before edge e, so edge e samples it
  task automatic key_at(input int e, input logic s);
    do @(negedge CLK); while (cyc < e - 1);
    kif.KEY_FLAG = 1'b1;
    kif.KEY_STATE = s;
    @(negedge CLK);
    kif.KEY_FLAG = 1'b0;
  endtask
  task automatic wait_to(input int c);
    do @(negedge CLK); while (cyc < c);
  endtask
  always @(negedge CLK) begin
    logic [3:0] v;
    int kind;
    exp_t x;
    v = {kif.DOUBLE_CLICK, kif.REPEAT, kif.LONG_PRESS, kif.SHORT_PRESS};
    if (v != 4'b0) begin
      chk("onehot", $countones(v), 1);
      kind = v[0] ? K_SHORT : v[1] ? K_LONG : v[2] ? K_REP : K_DBL;
      if (sb.size() == 0) chk("unexpected_event", kind, -1);
      else begin
        x = sb.pop_front();
        chk("event_kind", kind, x.kind);
        chk("event_cycle", cyc, x.at);
      end
    end
  end
  initial begin
    int p, q;
    kif.KEY_FLAG = 1'b0;
    kif.KEY_STATE = 1'b1;
    repeat (3) @(negedge CLK);
    chk("reset_outputs", 32'({kif.SHORT_PRESS, kif.LONG_PRESS, kif.REPEAT, kif.DOUBLE_CLICK, kif.KEY_HELD}), 0);
    nRST = 1'b1;
    p = cyc + 5;
    key_at(p, 1'b0);
    chk("held_after_press", 32'(kif.KEY_HELD), 1);
    key_at(p + 80, 1'b1);
    expect_evt(K_SHORT, p + 131);
    chk("held_after_release", 32'(kif.KEY_HELD), 0);
    wait_to(p + 200);
    p = cyc + 5;
    key_at(p, 1'b0);
    key_at(p + 30, 1'b1);
    key_at(p + 50, 1'b0);
    chk("held_in_pressed2", 32'(kif.KEY_HELD), 1);
    key_at(p + 60, 1'b1);
    expect_evt(K_DBL, p + 61);
    wait_to(p + 200);
    p = cyc + 5;
    key_at(p, 1'b0);
    expect_evt(K_LONG, p + 201);
    expect_evt(K_REP, p + 241);
    expect_evt(K_REP, p + 281);
    key_at(p + 300, 1'b1);
    chk("held_after_long_release", 32'(kif.KEY_HELD), 0);
    wait_to(p + 400);
    p = cyc + 5;
    key_at(p, 1'b0);
    key_at(p + 200, 1'b1);
    expect_evt(K_SHORT, p + 251);
    chk("held_release_at_expiry", 32'(kif.KEY_HELD), 0);
    wait_to(p + 300);
    p = cyc + 5;
    key_at(p, 1'b0);
    expect_evt(K_LONG, p + 201);
    wait_to(p + 220);
    chk("held_in_held", 32'(kif.KEY_HELD), 1);
    nRST = 1'b0;
    #1;
    chk("async_reset_outputs", 32'({kif.SHORT_PRESS, kif.LONG_PRESS, kif.REPEAT, kif.DOUBLE_CLICK, kif.KEY_HELD}), 0);
    wait_to(p + 225);
    nRST = 1'b1;
    wait_to(p + 330);
    chk("held_after_reset", 32'(kif.KEY_HELD), 0);
    q = cyc + 5;
    key_at(q, 1'b0);
    expect_evt(K_LONG, q + 201);
    expect_evt(K_REP, q + 241);
    key_at(q + 250, 1'b1);
    wait_to(q + 320);
    q = cyc + 5;
    key_at(q, 1'b1);
    p = q + 10;
    key_at(p, 1'b0);
    key_at(p + 50, 1'b0);
    expect_evt(K_LONG, p + 201);
    key_at(p + 210, 1'b1);
    wait_to(p + 300);
    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/key_event_decoder.md
# key_event_decoder

Consumes the debounced key interface (one-cycle KEY_FLAG pulse plus KEY_STATE level, 1 = released, 0 = pressed) and classifies each key gesture as a short press, long press, double click or auto-repeat. It sits between the per-button debouncer and the clock's time-set control logic. It emits one-cycle event pulses that the control FSM uses to advance or adjust hours and minutes.

## Interface
- CLK_HZ, 24_000_000: CLK frequency; sets the 1 ms prescaler terminal count CLK_HZ/1000-1.
- LONG_MS, 1000: hold time in ms that qualifies a long press.
- DBL_MS, 300: maximum ms from first release to second press for a double click.
- REPEAT_MS, 200: auto-repeat period in ms while held after a long press.
- CLK  in  1  system clock.
- nRST  in  1  reset, asynchronous, active-low.
- KEY_FLAG  in  1  one-cycle pulse on each debounced transition.
- KEY_STATE  in  1  debounced level; 1 = released, 0 = pressed. Sampled only when KEY_FLAG=1.
- SHORT_PRESS  out  1  one-cycle pulse: single click confirmed.
- LONG_PRESS  out  1  one-cycle pulse: hold reached LONG_MS.
- REPEAT  out  1  one-cycle pulse every REPEAT_MS after LONG_PRESS while still held.
- DOUBLE_CLICK  out  1  one-cycle pulse on release of the second press.
- KEY_HELD  out  1  registered level; 1 while the FSM is in PRESSED, PRESSED2 or HELD.

## Operation
- Event decode: press_evt = KEY_FLAG & !KEY_STATE. rel_evt = KEY_FLAG & KEY_STATE.
- States: IDLE, PRESSED, HELD, WAIT_DBL, PRESSED2. Encoding is one-hot; undefined codes go to IDLE with all outputs 0.
- IDLE: press_evt -> PRESSED. rel_evt is ignored.
- PRESSED:
  - rel_evt -> WAIT_DBL.
  - ms_cnt reaching LONG_MS -> pulse LONG_PRESS, go to HELD.
- HELD:
  - Every REPEAT_MS elapsed -> pulse REPEAT.
  - rel_evt -> IDLE. No SHORT_PRESS is issued.
- WAIT_DBL:
  - press_evt -> PRESSED2.
  - ms_cnt reaching DBL_MS -> pulse SHORT_PRESS, go to IDLE.
- PRESSED2:
  - rel_evt -> pulse DOUBLE_CLICK, go to IDLE.
  - ms_cnt reaching LONG_MS -> pulse LONG_PRESS, go to HELD. The first click is discarded with no SHORT_PRESS.
- Priority within one cycle: a KEY_FLAG event beats a timer expiry. Example: if rel_evt coincides with the LONG_MS expiry in PRESSED, the FSM goes to WAIT_DBL and LONG_PRESS is not issued.
- Events that do not match the current state are ignored and the state is held: press_evt in PRESSED, PRESSED2 or HELD; rel_evt in WAIT_DBL.
- Timer behaviour:
  - The prescaler (width ceil(log2(CLK_HZ/1000))) and the 16-bit ms_cnt both clear on every state transition.
  - In HELD they also clear on each REPEAT pulse.
  - ms_cnt increments on each prescaler wrap and saturates at 16'hFFFF.
- At most one event output is high in any cycle.

## Timing
- Reset values: state IDLE, all outputs 0, prescaler 0, ms_cnt 0.
- Reset mid-gesture aborts silently; no pulse is issued.
- All outputs are registered. A pulse caused by an input at edge N is high during the cycle after edge N+1.
- Expiry fires on the prescaler wrap that makes ms_cnt equal the threshold. Threshold T is therefore reached exactly T*(CLK_HZ/1000) clocks after state entry.
- REPEAT spacing is exactly REPEAT_MS*(CLK_HZ/1000) clocks. The first REPEAT comes REPEAT_MS after LONG_PRESS.
- KEY_HELD follows the state register with no added latency.

## Structure
- Package key_evt_pkg holds:
  - the state one-hot localparams (IDLE=5'b00001 … PRESSED2=5'b10000);
  - the default CLK_HZ, LONG_MS, DBL_MS and REPEAT_MS values;
  - the ms counter width constant (16).
- Sub-module ms_timer contains the prescaler plus ms_cnt.
  - Inputs: CLK, nRST, clr.
  - Outputs: ms_cnt[15:0], ms_wrap.
- The top level holds the FSM, the threshold compares and the output registers.

## Test plan
All scenarios use a bench with CLK_HZ=10_000 (10 clk/ms), LONG_MS=20, DBL_MS=5, REPEAT_MS=4.
- Press, release after 8 ms, no further press -> exactly one SHORT_PRESS, 50 clocks after the release flag (+1 cycle output latency). No other pulses.
- Press, release after 3 ms, press again 2 ms later, release -> one DOUBLE_CLICK, 1 cycle after the second release flag. No SHORT_PRESS.
- Press and hold 30 ms, then release:
  - LONG_PRESS 200 clocks after the press flag;
  - REPEAT at +40 and +80 clocks after LONG_PRESS;
  - nothing after the release.
- rel_evt on the same cycle the LONG_MS expiry would fire -> no LONG_PRESS; state WAIT_DBL. SHORT_PRESS follows 50 clocks later.
- nRST asserted while in HELD, then released -> all outputs 0, KEY_HELD=0, and no REPEAT until a new press plus 20 ms.
- rel_evt while in IDLE, and press_evt while in PRESSED -> ignored. State and timers are unchanged, checked against the expected LONG_PRESS time.
